key_debounce_scan: RTL and testbench
====================================

# key_debounce_scan

Multi-key debouncer and monophonic note selector for the synthesizer keyboard front end. It sits directly downstream of the D_FF synchroniser stage, which presents one already-synchronised level per key. It emits:
- clean per-key levels;
- one-cycle press and release strobes;
- a registered lowest-index-wins note number for the tone generator.

## Interface
Parameters:
- N_KEYS, default 8: number of keys; legal range 1..2^IDX_W.
- IDX_W, default 3: width of note_idx.
- CNT_W, default 16: width of each debounce counter.
- DEBOUNCE_CYCLES, default 50000: consecutive differing samples required to accept a change. Legal range 2..2^CNT_W.

Ports (clock and reset first):
- clk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset, sampled on the clk rising edge.
- key_sync  in  N_KEYS  synchronised raw key levels from the D_FF stage; 1 = pressed.
- key_stable  out  N_KEYS  debounced key levels.
- key_press  out  N_KEYS  one-cycle strobe on the cycle key_stable[i] goes 0→1.
- key_release  out  N_KEYS  one-cycle strobe on the cycle key_stable[i] goes 1→0.
- note_valid  out  1  1 when at least one key_stable bit is set (registered).
- note_idx  out  IDX_W  lowest index i with key_stable[i]=1 (registered).

## Operation
- There is one independent CNT_W-bit counter cnt[i] per key.
- Each edge, when key_sync[i] == key_stable[i]: cnt[i] ← 0.
- Each edge, when key_sync[i] != key_stable[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] ← cnt[i]+1.
- Each edge, when key_sync[i] != key_stable[i] and cnt[i] == DEBOUNCE_CYCLES-1:
  - key_stable[i] ← key_sync[i] and cnt[i] ← 0;
  - key_press[i] ← key_sync[i] and key_release[i] ← ~key_sync[i] on the same edge.
- key_press and key_release are 0 on every other edge. They are never both 1 for the same key.
- Any agreeing sample clears the count, so a glitch shorter than DEBOUNCE_CYCLES never changes key_stable.
- Keys are fully independent. Any number of press and release strobes may assert in the same cycle.
- Note selection uses lowest-index priority, evaluated on the current key_stable:
  - note_valid ← |key_stable;
  - note_idx ← lowest set index if any bit is set, otherwise note_idx holds its previous value. This lets a downstream release envelope keep its pitch.
- The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Reset (rst=1 at an edge) clears:
  - all cnt, key_stable, key_press and key_release bits to 0;
  - note_valid and note_idx to 0.
- Reset overrides all other activity, including a count in progress. The count restarts from 0 after reset.

## Timing
- Let key_sync[i] take a new value v ≠ key_stable[i] and be sampled equal to v on edges e1..eN, where N = DEBOUNCE_CYCLES.
  - key_stable[i] = v and the matching strobe are visible right after edge eN.
  - Total latency is exactly DEBOUNCE_CYCLES edges.
- The strobe is high for exactly one cycle, the cycle after eN.
- note_valid and note_idx update one edge after key_stable, i.e. after edge eN+1.
- Reset values are visible after the first edge with rst=1. Outputs stay at reset values while rst is held.
- There is no handshake. Downstream logic samples the strobes every cycle.

## Test plan
All scenarios use N_KEYS=8 and DEBOUNCE_CYCLES=4.
- Reset hold: key_sync=8'hFF with rst=1 for 3 edges → all outputs 0. Then deassert rst → key_stable=8'hFF and key_press=8'hFF after the 4th edge, key_press=0 the next cycle, note_valid=1 and note_idx=0 one edge later.
- Bounce rejection: key_sync[2] high 3 edges, low 1 edge, high 4 edges → key_stable[2] rises only after the final 4th high edge, with exactly one key_press[2] pulse and no key_release pulse.
- Priority: press key 5 (stable) → note_idx=5. Then press key 1 → note_idx=1. Release key 1 → note_idx=5. Release key 5 → note_valid=0 with note_idx holding 5.
- Release strobe: key 3 stable high, key_sync[3] low for 4 edges → key_stable[3]=0 and a key_release[3] 1-cycle pulse after the 4th edge, key_press stays 0.
- Reset mid-count: key_sync[0] high 2 edges, rst=1 for 1 edge with key still high → key_stable[0] rises only after 4 further edges following reset release.
- Simultaneous events: key 7 stable high; on the same edge drive key_sync[0]=1 and key_sync[7]=0, held 4 edges → key_press[0] and key_release[7] pulse in the same cycle, note_idx=0 one edge later.

Source files
------------

// File: rtl/key_debounce_scan.sv
// Per-key counter debouncer with press/release strobes and a registered
// lowest-index-wins note selector for a monophonic tone generator.
module key_debounce_scan #(
  parameter int unsigned N_KEYS          = 8,
  parameter int unsigned IDX_W           = 3,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_sync,
  output logic [N_KEYS-1:0] key_stable,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              note_valid,
  output logic [IDX_W-1:0]  note_idx
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_KEYS-1:0]            stable_q, stable_d;
  logic [N_KEYS-1:0]            press_q, press_d;
  logic [N_KEYS-1:0]            release_q, release_d;
  logic                         valid_q, valid_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [IDX_W-1:0]             lowest_idx;

  always_comb begin
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < int'(N_KEYS); i++) begin
      if (key_sync[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        stable_d[i]  = key_sync[i];
        cnt_d[i]     = '0;
        press_d[i]   = key_sync[i];
        release_d[i] = ~key_sync[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    lowest_idx = '0;
    for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
      if (stable_q[i]) lowest_idx = IDX_W'(i);
    end
  end

  // With no key held, the last pitch is kept for the release envelope.
  always_comb begin
    valid_d = |stable_q;
    idx_d   = valid_d ? lowest_idx : idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
    end
  end

  assign key_stable  = stable_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign note_valid  = valid_q;
  assign note_idx    = idx_q;

endmodule

// File: tb/tb_key_debounce_scan.sv
// Bench for key_debounce_scan: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a run-length reference model.
module tb_key_debounce_scan;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_sync;
  logic [7:0] key_stable, key_press, key_release;
  logic       note_valid;
  logic [2:0] note_idx;

  key_debounce_scan #(
    .N_KEYS         (8),
    .IDX_W          (3),
    .CNT_W          (16),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_sync   (key_sync),
    .key_stable (key_stable),
    .key_press  (key_press),
    .key_release(key_release),
    .note_valid (note_valid),
    .note_idx   (note_idx)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: a key flips once DEB consecutive samples disagree with its level.
  logic [7:0] m_stable = '0, m_press = '0, m_release = '0;
  logic       m_valid  = 1'b0;
  logic [2:0] m_idx    = '0;
  int         run [8];

  always @(posedge clk) begin
    if (rst) begin
      m_stable = '0; m_press = '0; m_release = '0; m_valid = 1'b0; m_idx = '0;
      for (int k = 0; k < 8; k++) run[k] = 0;
    end else begin
      m_valid = (m_stable != 0);
      for (int k = 7; k >= 0; k--) if (m_stable[k]) m_idx = 3'(k);
      m_press = '0; m_release = '0;
      for (int k = 0; k < 8; k++) begin
        if (key_sync[k] != m_stable[k]) begin
          run[k]++;
          if (run[k] == DEB) begin
            m_stable[k]  = key_sync[k];
            m_press[k]   = key_sync[k];
            m_release[k] = ~key_sync[k];
            run[k]       = 0;
          end
        end else begin
          run[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_stable",  32'(key_stable),  32'(m_stable));
      check("model_press",   32'(key_press),   32'(m_press));
      check("model_release", 32'(key_release), 32'(m_release));
      check("model_valid",   32'(note_valid),  32'(m_valid));
      check("model_idx",     32'(note_idx),    32'(m_idx));
      n_total++;
      if ((key_press & key_release) == 0) n_pass++;
      else $display("FAIL press_and_release: got %0h expected 0", key_press & key_release);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; key_sync = '0;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    // Reset hold with all keys high
    rst = 1'b1; key_sync = 8'hFF;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    check("rst_stable", 32'(key_stable), 32'h0);
    check("rst_press",  32'(key_press),  32'h0);
    check("rst_valid",  32'(note_valid), 32'h0);
    check("rst_idx",    32'(note_idx),   32'h0);
    rst = 1'b0;
    tick(3);
    check("hold_early_stable", 32'(key_stable), 32'h0);
    tick(1);
    check("hold_stable", 32'(key_stable), 32'hFF);
    check("hold_press",  32'(key_press),  32'hFF);
    check("hold_valid0", 32'(note_valid), 32'h0);
    tick(1);
    check("hold_press_off", 32'(key_press),  32'h0);
    check("hold_valid",     32'(note_valid), 32'h1);
    check("hold_idx",       32'(note_idx),   32'h0);

    // Bounce rejection on key 2
    do_reset();
    key_sync = 8'h04; tick(3);
    key_sync = 8'h00; tick(1);
    key_sync = 8'h04; tick(3);
    check("bounce_early", 32'(key_stable), 32'h0);
    tick(1);
    check("bounce_stable",  32'(key_stable),  32'h04);
    check("bounce_press",   32'(key_press),   32'h04);
    check("bounce_release", 32'(key_release), 32'h0);

    // Priority
    do_reset();
    key_sync = 8'h20; tick(5);
    check("prio_5", 32'(note_idx), 32'd5);
    key_sync = 8'h22; tick(5);
    check("prio_1", 32'(note_idx), 32'd1);
    key_sync = 8'h20; tick(5);
    check("prio_back5", 32'(note_idx), 32'd5);
    key_sync = 8'h00; tick(5);
    check("prio_none_valid", 32'(note_valid), 32'h0);
    check("prio_none_hold",  32'(note_idx),   32'd5);

    // Release strobe on key 3
    do_reset();
    key_sync = 8'h08; tick(5);
    key_sync = 8'h00; tick(3);
    check("rel_early", 32'(key_stable), 32'h08);
    tick(1);
    check("rel_stable",  32'(key_stable),  32'h0);
    check("rel_release", 32'(key_release), 32'h08);
    check("rel_press",   32'(key_press),   32'h0);
    tick(1);
    check("rel_off", 32'(key_release), 32'h0);

    // Reset in the middle of a count
    do_reset();
    key_sync = 8'h01; tick(2);
    rst = 1'b1; tick(1);
    rst = 1'b0; tick(3);
    check("midrst_early", 32'(key_stable), 32'h0);
    tick(1);
    check("midrst_stable", 32'(key_stable), 32'h01);
    check("midrst_press",  32'(key_press),  32'h01);

    // Simultaneous press and release
    do_reset();
    key_sync = 8'h80; tick(5);
    check("sim_idx7", 32'(note_idx), 32'd7);
    key_sync = 8'h01; tick(4);
    check("sim_press",   32'(key_press),   32'h01);
    check("sim_release", 32'(key_release), 32'h80);
    tick(1);
    check("sim_idx0", 32'(note_idx), 32'd0);

    // Randomized traffic: sparse bit flips so some changes survive debouncing
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 8; k++) if ($urandom_range(0, 5) == 0) key_sync[k] = ~key_sync[k];
      rst = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
